// File: rtl/ro_meter_pkg.sv
`timescale 1ns/1ps
// Shared FSM encoding, synchronizer depth and sizing helper for the ring-oscillator meter.
package ro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } meter_state_e;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + 2;

    // Width of the stage selector able to address lengths 1,3,..,max_stages.
    function automatic int unsigned sel_width(input int unsigned max_stages);
        int unsigned w;
        w = $clog2((max_stages + 1) / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ring_osc_prog.sv
`timescale 1ns/1ps
// Programmable-length ring oscillator: odd inverter chain with a muxed feedback tap and enable.
// R_OSC_SYNTHESIS drops the per-inverter simulation delay and leaves a plain combinational ring.
module ring_osc_prog import ro_meter_pkg::*; #(
    parameter int unsigned MAX_STAGES   = 7,
    parameter int unsigned INV_DELAY_ns = 107,
    parameter int unsigned SEL_W        = 2
) (
    input  logic             en,
    input  logic [SEL_W-1:0] stage_sel,
    output logic             clk_out
);

    localparam int unsigned MAX_SEL = (MAX_STAGES - 1) / 2;
    localparam int unsigned TAP_W   = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1;

    logic [MAX_STAGES-1:0] node;
    logic [TAP_W-1:0]      tap_c;
    logic                  fb_c;
    int unsigned           sel_c;

    // Ring length 2*sel+1 means the feedback is taken after inverter index 2*sel.
    always_comb begin
        sel_c = 32'(stage_sel);
        if (sel_c > MAX_SEL) begin
            sel_c = MAX_SEL;
        end
        tap_c = TAP_W'(2 * sel_c);
    end

    assign fb_c = node[tap_c];

`ifdef R_OSC_SYNTHESIS
    assign node = {~node[MAX_STAGES-2:0], ~(en & fb_c)};
`else
    // Every inverter updates once per INV_DELAY_ns from its input's previous value.
    always begin
        #(INV_DELAY_ns);
        node <= {~node[MAX_STAGES-2:0], ~(en & fb_c)};
    end
`endif

    assign clk_out = en & fb_c;

endmodule

// File: rtl/ring_osc_meter.sv
`timescale 1ns/1ps
// Ring-oscillator bank with a windowed, synchronised edge-count frequency meter per channel.
// RO_METER_BOTH_EDGES_EN counts both synchronised edges instead of rising edges only.
module ring_osc_meter import ro_meter_pkg::*; #(
    parameter  int unsigned NO_CHANNELS  = 4,
    parameter  int unsigned MAX_STAGES   = 7,
    parameter  int unsigned INV_DELAY_ns = 107,
    parameter  int unsigned CNT_W        = 16,
    parameter  int unsigned WIN_W        = 16,
    localparam int unsigned SEL_W        = sel_width(MAX_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIN_W-1:0]             win_len,
    input  logic [SEL_W-1:0]             stage_sel,
    input  logic [NO_CHANNELS-1:0]       ch_en,
    output logic                         busy,
    output logic                         done,
    output logic [NO_CHANNELS*CNT_W-1:0] count,
    output logic [NO_CHANNELS-1:0]       overflow,
    output logic [NO_CHANNELS-1:0]       ro_clk
);

    meter_state_e state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d, tmr_q, tmr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NO_CHANNELS-1:0] ch_q, ch_d, ring_en_q, ring_en_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [NO_CHANNELS-1:0][CNT_W-1:0] wcnt_q, wcnt_d, cnt_q, cnt_d;
    logic [NO_CHANNELS-1:0] wovf_q, wovf_d, ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0][NO_CHANNELS-1:0] sync_q;
    logic [NO_CHANNELS-1:0] prev_q, edge_c;

    for (genvar k = 0; k < NO_CHANNELS; k++) begin : g_ch
        ring_osc_prog #(
            .MAX_STAGES  (MAX_STAGES),
            .INV_DELAY_ns(INV_DELAY_ns),
            .SEL_W       (SEL_W)
        ) u_ring (
            .en       (ring_en_q[k]),
            .stage_sel(sel_q),
            .clk_out  (ro_clk[k])
        );
    end

`ifdef RO_METER_BOTH_EDGES_EN
    assign edge_c = sync_q[SYNC_STAGES-1] ^ prev_q;
`else
    assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;
`endif

    // Measurement sequencing, window timing and saturating per-channel counters.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        tmr_d     = tmr_q;
        sel_d     = sel_q;
        ch_d      = ch_q;
        ring_en_d = ring_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wcnt_d    = wcnt_q;
        wovf_d    = wovf_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    win_d     = win_len;
                    sel_d     = stage_sel;
                    ch_d      = ch_en;
                    ring_en_d = ch_en;
                    busy_d    = 1'b1;
                    tmr_d     = '0;
                    wcnt_d    = '0;
                    wovf_d    = '0;
                end
            end
            SETTLE: begin
                if (tmr_q == WIN_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = (win_q == '0) ? REPORT : MEASURE;
                end else begin
                    tmr_d = tmr_q + WIN_W'(1);
                end
            end
            MEASURE: begin
                for (int unsigned k = 0; k < NO_CHANNELS; k++) begin
                    if (ch_q[k] && edge_c[k]) begin
                        if (&wcnt_q[k]) begin
                            wovf_d[k] = 1'b1;
                        end else begin
                            wcnt_d[k] = wcnt_q[k] + CNT_W'(1);
                        end
                    end
                end
                if (tmr_q == win_q - WIN_W'(1)) begin
                    state_d = REPORT;
                end else begin
                    tmr_d = tmr_q + WIN_W'(1);
                end
            end
            REPORT: begin
                cnt_d     = wcnt_q;
                ovf_d     = wovf_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                ring_en_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_q     <= '0;
            tmr_q     <= '0;
            sel_q     <= '0;
            ch_q      <= '0;
            ring_en_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wcnt_q    <= '0;
            wovf_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            tmr_q     <= tmr_d;
            sel_q     <= sel_d;
            ch_q      <= ch_d;
            ring_en_q <= ring_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wcnt_q    <= wcnt_d;
            wovf_q    <= wovf_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ro_clk};
            prev_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
// Bench for ring_osc_meter: directed table, busy-restart and reset sequences, random runs
// checked against an edges-per-window frequency model; a 4-bit-counter copy checks saturation.
module tb_ring_osc_meter;
    import ro_meter_pkg::*;

    localparam int NCH     = 4;
    localparam int CW      = 16;
    localparam int CWN     = 4;
    localparam int WW      = 16;
    localparam int SW      = 2;
    localparam int D_NS    = 107;
    localparam int TCLK_NS = 20;
    localparam int MAX_SEL = 3;
    localparam int NSAT    = 15;
`ifdef RO_METER_BOTH_EDGES_EN
    localparam int EDGE_MULT = 2;
`else
    localparam int EDGE_MULT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [WW-1:0] win_len = '0;
    logic [SW-1:0] stage_sel = '0;
    logic [NCH-1:0] ch_en = '0;

    logic busy, done, busy_n, done_n;
    logic [NCH*CW-1:0] count;
    logic [NCH*CWN-1:0] count_n;
    logic [NCH-1:0] overflow, ro_clk, overflow_n, ro_clk_n;

    int total = 0;
    int bad = 0;
    int seen;
    int lo, hi;

    typedef struct {
        int             sel;
        logic [NCH-1:0] ch;
        int             win;
        int             lo;
        int             hi;
    } vec_t;
    vec_t tbl[6];

    ring_osc_meter dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .stage_sel(stage_sel),
        .ch_en(ch_en), .busy(busy), .done(done), .count(count), .overflow(overflow),
        .ro_clk(ro_clk)
    );

    ring_osc_meter #(.CNT_W(CWN)) dut_n (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .stage_sel(stage_sel),
        .ch_en(ch_en), .busy(busy_n), .done(done_n), .count(count_n), .overflow(overflow_n),
        .ro_clk(ro_clk_n)
    );

    always #10 clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint elo, input longint ehi);
        total++;
        if (act < elo || act > ehi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, elo, ehi);
        end
    endtask

    // Edges in a window = window time / ring period, allowing the +-1 quantisation.
    function automatic void model(input int sel, input int win, output int elo, output int ehi);
        int stages, num, den;
        stages = 2 * ((sel > MAX_SEL) ? MAX_SEL : sel) + 1;
        num = win * TCLK_NS * EDGE_MULT;
        den = 2 * stages * D_NS;
        elo = num / den;
        ehi = (num + den - 1) / den + (EDGE_MULT - 1);
    endfunction

    function automatic int min_sat(input int v);
        return (v > NSAT) ? NSAT : v;
    endfunction

    task automatic run_meas(input string tag, input int sel, input logic [NCH-1:0] ch,
                            input int win, input int elo, input int ehi, input int poke);
        int lat, exp_lat, pulses;
        @(negedge clk);
        stage_sel = SW'(sel);
        ch_en     = ch;
        win_len   = WW'(win);
        start     = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 1;
        exp_lat = 2 + int'(SETTLE_CYCLES) + win;
        check({tag, "_busy"}, busy, 1, 1);
        while (done !== 1'b1 && lat < exp_lat + 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke) begin
                start = 1'b1; win_len = WW'(5); stage_sel = '0; ch_en = '1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, exp_lat, exp_lat);
        check({tag, "_busy_at_done"}, busy, 0, 0);
        for (int k = 0; k < NCH; k++) begin
            if (ch[k]) begin
                check($sformatf("%s_cnt%0d", tag, k), count[k*CW +: CW], elo, ehi);
                check($sformatf("%s_ovf%0d", tag, k), overflow[k], 0, 0);
                check($sformatf("%s_ncnt%0d", tag, k), count_n[k*CWN +: CWN], min_sat(elo), min_sat(ehi));
                if (elo > NSAT)
                    check($sformatf("%s_novf%0d", tag, k), overflow_n[k], 1, 1);
                else if (ehi <= NSAT)
                    check($sformatf("%s_novf%0d", tag, k), overflow_n[k], 0, 0);
            end else begin
                check($sformatf("%s_cnt%0d", tag, k), count[k*CW +: CW], 0, 0);
                check($sformatf("%s_ovf%0d", tag, k), overflow[k], 0, 0);
                check($sformatf("%s_ncnt%0d", tag, k), count_n[k*CWN +: CWN], 0, 0);
                check($sformatf("%s_novf%0d", tag, k), overflow_n[k], 0, 0);
            end
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check({tag, "_extra_done"}, pulses, 0, 0);
        check({tag, "_ro_clk_off"}, ro_clk, 0, 0);
        check({tag, "_busy_after"}, busy, 0, 0);
        repeat (60) @(posedge clk);
    endtask

    initial begin
`ifdef RO_METER_BOTH_EDGES_EN
        tbl[0] = '{1, 4'b0001, 1000, 62, 64};
        tbl[1] = '{2, 4'b0001, 1000, 37, 39};
        tbl[2] = '{3, 4'b1010, 1000, 26, 28};
        tbl[3] = '{0, 4'b1111, 1000, 186, 188};
`else
        tbl[0] = '{1, 4'b0001, 1000, 31, 32};
        tbl[1] = '{2, 4'b0001, 1000, 18, 19};
        tbl[2] = '{3, 4'b1010, 1000, 13, 14};
        tbl[3] = '{0, 4'b1111, 1000, 93, 94};
`endif
        tbl[4] = '{1, 4'b0000, 200, 0, 0};
        tbl[5] = '{0, 4'b0001, 0, 0, 0};

        repeat (10) @(posedge clk);
        #1;
        check("reset_busy", busy, 0, 0);
        check("reset_done", done, 0, 0);
        check("reset_count", count, 0, 0);
        check("reset_overflow", overflow, 0, 0);
        check("reset_ro_clk", ro_clk, 0, 0);
        @(negedge clk) rst = 1'b0;
        repeat (60) @(posedge clk);

        for (int i = 0; i < 6; i++)
            run_meas($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].ch, tbl[i].win, tbl[i].lo, tbl[i].hi, -1);

        model(1, 300, lo, hi);
        run_meas("restart_ignored", 1, 4'b0001, 300, lo, hi, 20);

        // Reset partway through a window: everything clears at once and no done follows.
        @(negedge clk);
        stage_sel = 2'd1; ch_en = 4'b0011; win_len = WW'(1000); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0, 0);
        check("midrst_done", done, 0, 0);
        check("midrst_count", count, 0, 0);
        check("midrst_overflow", overflow, 0, 0);
        check("midrst_ncount", count_n, 0, 0);
        check("midrst_ro_clk", ro_clk, 0, 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (1010) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0, 0);
        model(2, 500, lo, hi);
        run_meas("after_rst", 2, 4'b0110, 500, lo, hi, -1);

        for (int i = 0; i < 8; i++) begin
            int s, w;
            logic [NCH-1:0] c;
            s = int'($urandom_range(0, 3));
            w = int'($urandom_range(0, 300));
            c = NCH'($urandom_range(0, 15));
            model(s, w, lo, hi);
            run_meas($sformatf("rnd%0d", i), s, c, w, lo, hi, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
